pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register with valid/ready handshake, flush, and an optional skid entry. It replaces the fixed, always-advancing stage registers between fetch, decode, execute, memory and writeback. Back-pressure from a stalled downstream stage is absorbed without data loss. With `SKID=1`, the upstream ready path is cut to a register output. One instance sits on each stage boundary; the payload is the stage's packed data struct, flattened to `WIDTH` bits.

## Interface
Parameters:
- `WIDTH`, 64: payload width in bits; must be ≥1.
- `SKID`, 1: 1 gives a two-entry skid buffer with registered `in_ready`; 0 gives a single entry with combinational `in_ready`.
- `CNT_W`, 32: width of the stall counter; must be ≥1.

Ports:
- `clk` in, 1: clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `flush` in, 1: synchronous squash of all held entries (branch mispredict / exception).
- `in_valid` in, 1: upstream has a payload.
- `in_ready` out, 1: stage accepts a payload this cycle.
- `in_data` in, `WIDTH`: upstream payload.
- `out_valid` out, 1: `out_data` holds a live payload.
- `out_ready` in, 1: downstream consumes this cycle.
- `out_data` out, `WIDTH`: head payload, driven directly from the main register.
- `stall_cnt` out, `CNT_W`: saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Handshake events:
  - in-fire = `in_valid && in_ready`.
  - out-fire = `out_valid && out_ready`.
  - `in_valid` may drop without a fire; no payload is ever duplicated or lost absent `flush`/`reset`.
- Storage: main register (`main_v`, `main_d`); when `SKID=1`, also a skid register (`skid_v`, `skid_d`).
- `SKID=1` states and transitions:
  - EMPTY (`main_v=0`, `skid_v=0`): in-fire → FULL, `main_d<=in_data`.
  - FULL (`main_v=1`, `skid_v=0`):
    - in-fire and out-fire → FULL, `main_d<=in_data`.
    - in-fire only → SKID, `skid_d<=in_data`.
    - out-fire only → EMPTY.
    - neither → hold.
  - SKID (`main_v=1`, `skid_v=1`): `in_ready=0`.
    - out-fire → FULL, `main_d<=skid_d`.
    - no out-fire → hold.
  - SKID is reachable only from FULL.
  - `in_ready = !skid_v`, a pure register output.
- `SKID=0`:
  - `in_ready = !main_v || out_ready`.
  - in-fire loads `main_d`.
  - out-fire without in-fire clears `main_v`.
- `out_valid = main_v`; `out_data = main_d`. `out_data` is don't-care when `out_valid=0` but must not change while `out_valid=1` and `out_ready=0`.
- Flush:
  - Clears `main_v` and `skid_v` at the edge.
  - Any in-fire in the same cycle is discarded.
  - Data registers keep their contents.
  - `stall_cnt` is unaffected.
- `stall_cnt`:
  - Increments by 1 on each edge where `out_valid && !out_ready && !flush`.
  - Saturates at `2^CNT_W-1`; no wrap.
- Priority: `reset` > `flush` > normal transitions.
- Reset:
  - All valids cleared; `main_d`, `skid_d` and `stall_cnt` set to 0.
  - Applies regardless of state, including mid-SKID.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `stall_cnt=0`.
  - `in_ready=1` in both modes.
- Latency: a payload accepted at edge N is visible on `out_data`, with `out_valid=1`, in cycle N+1.
- Throughput: 1 payload/cycle sustained while `out_ready=1`, in both modes.
- `SKID=1`:
  - `in_ready` falls in the cycle after the second unconsumed acceptance.
  - `in_ready` rises in the cycle after the out-fire that drains the skid entry.
  - Order is preserved: the main entry exits before the skid entry.
- `SKID=0`: `in_ready` depends combinationally on `out_ready`; no other in→out combinational path exists in either mode.
- After `flush` at edge N: `out_valid=0` and `in_ready=1` in cycle N+1; a new payload can be accepted in cycle N+1.
- Simultaneous `flush` and out-fire: downstream treats the payload as consumed. The stage only guarantees it is gone at N+1.

## Test plan
- Reset, `SKID=1`, `WIDTH=64`: hold `reset` for 2 cycles → `out_valid=0`, `out_data=0`, `in_ready=1`, `stall_cnt=0`.
- Streaming: `out_ready=1`, send `0x11,0x22,0x33` on consecutive cycles → same values appear on consecutive cycles, each 1 cycle after acceptance; `in_ready` stays 1.
- Back-pressure: send `0xA1`, `0xA2` with `out_ready=0` → `in_ready=0` from the cycle after `0xA2` is accepted; `out_data=0xA1` held. Then raise `out_ready` → `0xA1` then `0xA2`, with `in_ready=1` the cycle after `0xA1` exits. `stall_cnt` equals the number of stalled cycles.
- Flush in SKID state: with `0xB1` and `0xB2` held, assert `flush` together with `in_valid`/`0xB3` → next cycle `out_valid=0`, `in_ready=1`; none of `0xB1`, `0xB2`, `0xB3` ever emerge.
- `SKID=0`: `out_valid=1`, `out_ready=0` → `in_ready=0` in the same cycle. Raise `out_ready` → `in_ready=1` combinationally, new payload replaces the old at the next edge.
- Saturation, `CNT_W=3`: stall for 10 cycles → `stall_cnt` reaches 7 and holds. `reset` mid-stall → 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an optional
// skid entry that cuts the upstream ready path to a register output.
module pipe_stage_reg #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  // With a skid entry, ready is a pure register decode; without one it looks through to out_ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != ST_SKID);
    end else begin : g_no_skid
      assign in_ready = (state_q == ST_EMPTY) || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_FULL;
            main_data_d = in_data;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
          end else if (in_fire) begin
            // Only reachable with SKID != 0: without a skid entry in-fire implies out-fire here.
            state_d     = ST_SKID;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d     = ST_FULL;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: reset is synchronous, so it is sampled inside the posedge-only block; state uses <= only.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: payload registers are reset too so out_data reads 0 after reset.
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three pipe_stage_reg configurations checked every cycle
// against a FIFO-occupancy reference model, with directed and random stimulus.
module tb_pipe_stage_reg;

  localparam int N = 3;  // 0: SKID=1 CNT_W=32, 1: SKID=0 CNT_W=32, 2: SKID=1 CNT_W=3

  logic        clk;
  logic        rs  [N];
  logic        fl  [N];
  logic        iv  [N];
  logic        ir  [N];
  logic [63:0] id  [N];
  logic        ov  [N];
  logic        ord [N];
  logic [63:0] od  [N];
  logic [31:0] sc0, sc1;
  logic [2:0]  sc2;

  int checks   = 0;
  int failures = 0;

  // Reference model: a FIFO with per-mode capacity and a saturating stall counter.
  bit          m_known [N];
  int          m_size  [N];
  logic [63:0] m_e0    [N];
  logic [63:0] m_e1    [N];
  logic [63:0] m_cnt   [N];
  bit          m_skid  [N] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] m_max   [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};

  pipe_stage_reg #(.WIDTH(64), .SKID(1), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset(rs[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ord[0]), .out_data(od[0]), .stall_cnt(sc0)
  );
  pipe_stage_reg #(.WIDTH(64), .SKID(0), .CNT_W(32)) u_dut1 (
    .clk(clk), .reset(rs[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ord[1]), .out_data(od[1]), .stall_cnt(sc1)
  );
  pipe_stage_reg #(.WIDTH(64), .SKID(1), .CNT_W(3)) u_dut2 (
    .clk(clk), .reset(rs[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .out_valid(ov[2]), .out_ready(ord[2]), .out_data(od[2]), .stall_cnt(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_sc(input int i);
    case (i)
      0:       return {32'd0, sc0};
      1:       return {32'd0, sc1};
      default: return {61'd0, sc2};
    endcase
  endfunction

  function automatic bit model_ready(input int i);
    if (m_skid[i]) return m_size[i] < 2;
    return (m_size[i] == 0) || ord[i];
  endfunction

  task automatic compare(input int i);
    if (!m_known[i]) return;
    check($sformatf("u%0d.in_ready", i), {63'd0, ir[i]}, {63'd0, model_ready(i)});
    check($sformatf("u%0d.out_valid", i), {63'd0, ov[i]}, {63'd0, m_size[i] > 0});
    if (m_size[i] > 0) check($sformatf("u%0d.out_data", i), od[i], m_e0[i]);
    check($sformatf("u%0d.stall_cnt", i), dut_sc(i), m_cnt[i]);
  endtask

  task automatic model_step(input int i);
    bit rdy, fi, fo;
    rdy = model_ready(i);
    if (rs[i]) begin
      m_size[i]  = 0;
      m_cnt[i]   = 0;
      m_e0[i]    = 0;
      m_known[i] = 1'b1;
      return;
    end
    if (!m_known[i]) return;
    if (m_size[i] > 0 && !ord[i] && !fl[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
    if (fl[i]) begin
      m_size[i] = 0;
      return;
    end
    fo = (m_size[i] > 0) && ord[i];
    fi = iv[i] && rdy;
    if (fo) begin
      m_e0[i] = m_e1[i];
      m_size[i]--;
    end
    if (fi) begin
      if (m_size[i] == 0) m_e0[i] = id[i];
      else                m_e1[i] = id[i];
      m_size[i]++;
    end
  endtask

  // One clock cycle: inputs already applied; compare mid-cycle, advance model, cross the edge.
  task automatic tick();
    #3;
    for (int i = 0; i < N; i++) compare(i);
    for (int i = 0; i < N; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic v, input logic [63:0] d);
    iv[i] = v;
    id[i] = d;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rs[i] = 1'b1; fl[i] = 1'b0; iv[i] = 1'b0; id[i] = '0; ord[i] = 1'b0;
      m_known[i] = 1'b0; m_size[i] = 0; m_e0[i] = '0; m_e1[i] = '0; m_cnt[i] = '0;
    end
    @(posedge clk);
    #1;

    // Reset held for two cycles.
    tick();
    tick();
    for (int i = 0; i < N; i++) rs[i] = 1'b0;
    check("rst.out_data", od[0], 64'd0);
    check("rst.out_valid", {63'd0, ov[0]}, 64'd0);
    check("rst.stall_cnt", dut_sc(0), 64'd0);
    tick();

    // Streaming with out_ready high.
    ord[0] = 1'b1;
    send(0, 1'b1, 64'h11); tick();
    send(0, 1'b1, 64'h22); tick();
    send(0, 1'b1, 64'h33); tick();
    send(0, 1'b0, 64'h0);
    repeat (2) tick();

    // Back-pressure into the skid entry, then drain.
    ord[0] = 1'b0;
    send(0, 1'b1, 64'hA1); tick();
    send(0, 1'b1, 64'hA2); tick();
    send(0, 1'b1, 64'hA3);
    repeat (3) tick();
    check("bp.held_data", od[0], 64'hA1);
    check("bp.in_ready_low", {63'd0, ir[0]}, 64'd0);
    send(0, 1'b0, 64'h0);
    ord[0] = 1'b1;
    repeat (3) tick();

    // Flush while in the skid state, with a simultaneous in_valid.
    ord[0] = 1'b0;
    send(0, 1'b1, 64'hB1); tick();
    send(0, 1'b1, 64'hB2); tick();
    send(0, 1'b1, 64'hB3);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    send(0, 1'b0, 64'h0);
    check("flush.out_valid", {63'd0, ov[0]}, 64'd0);
    check("flush.in_ready", {63'd0, ir[0]}, 64'd1);
    ord[0] = 1'b1;
    repeat (3) tick();

    // Single-entry mode: combinational ready and replace-on-fire.
    ord[1] = 1'b0;
    send(1, 1'b1, 64'hC1); tick();
    send(1, 1'b1, 64'hC2);
    repeat (2) tick();
    ord[1] = 1'b1;
    tick();
    check("noskid.replaced", od[1], 64'hC2);
    send(1, 1'b0, 64'h0);
    repeat (2) tick();

    // Stall counter saturation, then reset mid-stall.
    ord[2] = 1'b0;
    send(2, 1'b1, 64'hD1); tick();
    send(2, 1'b0, 64'h0);
    repeat (10) tick();
    check("sat.stall_cnt", dut_sc(2), 64'd7);
    rs[2] = 1'b1;
    tick();
    rs[2] = 1'b0;
    check("sat.reset_cnt", dut_sc(2), 64'd0);
    tick();

    // Random traffic on all three instances.
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        iv[i]  = 1'($urandom_range(0, 1));
        id[i]  = {$urandom, $urandom};
        ord[i] = ($urandom_range(0, 3) != 0);
        fl[i]  = ($urandom_range(0, 15) == 0);
        rs[i]  = ($urandom_range(0, 63) == 0);
      end
      tick();
    end

    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; rs[i] = 1'b0; ord[i] = 1'b1;
    end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
